pipeline_redirect_scheduler: RTL
================================

Name: pipeline_redirect_scheduler

Overview:
- Sequences all control-flow redirects and stage stalls for the 5-stage in-order core (IF, ID, EX, MEM, WB).
- Arbitrates three redirect sources (exception, ertn, branch mispredict) and emits per-stage flush/stall vectors.
- Holds the winning redirect PC in a registered valid/ready handshake until fetch accepts it.
- Keeps mispredict/exception event counters for performance monitoring.

Parameters:
ADDR_WIDTH, 32, PC width
CNT_WIDTH, 32, width of each event counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
predict_miss  in  1  EX-stage branch resolution disagrees with prediction
real_addr  in  ADDR_WIDTH  correct target for predict_miss
exp_en  in  1  exception taken at MEM (commit point)
trap_entry  in  ADDR_WIDTH  exception entry PC
e_ret  in  1  ertn executing at MEM
epc  in  ADDR_WIDTH  return PC for e_ret
mem_stall  in  1  MEM stage multi-cycle access busy
ex_stall  in  1  EX multi-cycle unit (mul/div) busy
load_use  in  1  ID load-use hazard
redirect_ready  in  1  fetch accepts redirect this cycle
flush  out  5  per-stage flush, bit4=IF, bit3=ID, bit2=EX, bit1=MEM, bit0=WB
stall  out  5  per-stage stall, same bit order
redirect_valid  out  1  pending redirect to fetch
redirect_pc  out  ADDR_WIDTH  redirect target
mispredict_cnt  out  CNT_WIDTH  accepted mispredict events
exception_cnt  out  CNT_WIDTH  accepted exception + ertn events

Behaviour:
- Reset (async, rst_n=0): state=IDLE; redirect_valid=0, redirect_pc=0, both counters=0. flush and stall evaluate to 0 while in reset. Reset mid-REDIRECT drops the pending redirect.
- Event priority (same cycle): exp_en > e_ret > predict_miss. Only the winner is recorded and counted.
- Flush vector, combinational in the event cycle N:
  - exp_en or e_ret: 5'b11110.
  - predict_miss alone: 5'b11000.
  - load_use with no redirect event: flush[2]=1 (EX bubble).
- Stall vector, combinational:
  - mem_stall: 5'b11110.
  - else ex_stall: 5'b11100.
  - else load_use: 5'b11000.
  - Final stall = stall & ~flush; flush always wins per stage.
- FSM, two states:
  - IDLE: a winning event at cycle N loads redirect_pc with trap_entry, epc or real_addr. It sets redirect_valid=1 from cycle N+1 and moves to REDIRECT.
  - REDIRECT:
    - redirect_valid=1 and redirect_pc held stable.
    - flush[4]=1 every cycle to kill wrong-path fetch.
    - Handshake completes on redirect_valid && redirect_ready. Next cycle: redirect_valid=0, state=IDLE.
    - predict_miss is ignored, not counted, and gets no flush (it comes from an already-flushed path).
    - exp_en/e_ret override: redirect_pc reloads, flush 5'b11110 that cycle, counter increments, state stays REDIRECT. This applies even in the handshake-completion cycle: the override wins and redirect_valid stays 1.
  - A new event in the same cycle as the IDLE transition is handled as an IDLE event in that next cycle.
- Back-to-back handshake: the minimum redirect latency is 1 cycle, event N -> redirect_valid at N+1.
  - If redirect_ready=1 at N+1, state returns to IDLE at N+2.
  - A new event at N+1 in the handshake cycle follows the REDIRECT rules above.
- Counters: increment by 1 per counted event, wrap modulo 2^CNT_WIDTH, no saturation.
- No combinational path from redirect_ready to flush or stall.

Test Plan:
- Reset mid-REDIRECT: predict_miss, real_addr=0x1C00_0100, redirect_ready=0 for 3 cycles, then rst_n=0.
  -> redirect_valid=0, redirect_pc=0, counters=0 immediately.
  -> After release, flush=0 with no inputs.
- Simple mispredict: predict_miss at cycle 10, real_addr=0x1C00_0040, redirect_ready=1.
  -> flush=5'b11000 at cycle 10.
  -> redirect_valid=1, redirect_pc=0x1C00_0040, flush=5'b10000 at cycle 11.
  -> IDLE at 12; mispredict_cnt=1.
- Simultaneous exp_en + predict_miss, trap_entry=0x1C00_8000:
  -> flush=5'b11110, redirect_pc=0x1C00_8000.
  -> exception_cnt=1, mispredict_cnt=0.
- Override in REDIRECT: mispredict pending to 0x100 with redirect_ready=0, then e_ret with epc=0x200.
  -> flush=5'b11110, redirect_pc=0x200 next cycle, still valid.
  -> Counters: mispredict_cnt=1, exception_cnt=1.
- Stall merge: mem_stall=1, load_use=1, no events -> stall=5'b11110, flush=5'b00100, so final stall=5'b11010.
  - ex_stall alone -> stall=5'b11100.
- Counter wrap: CNT_WIDTH=4, 17 accepted mispredicts -> mispredict_cnt=1.

Source files
------------

// File: rtl/pipeline_redirect_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_redirect_scheduler_if
// Brief    : Event, hazard and redirect-handshake bundle for the scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_redirect_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) ();
    logic                  predict_miss;
    logic [ADDR_WIDTH-1:0] real_addr;
    logic                  exp_en;
    logic [ADDR_WIDTH-1:0] trap_entry;
    logic                  e_ret;
    logic [ADDR_WIDTH-1:0] epc;
    logic                  mem_stall;
    logic                  ex_stall;
    logic                  load_use;
    logic                  redirect_ready;
    logic [4:0]            flush;
    logic [4:0]            stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  mispredict_cnt;
    logic [CNT_WIDTH-1:0]  exception_cnt;

    modport slave (
        input  predict_miss, real_addr, exp_en, trap_entry, e_ret, epc,
               mem_stall, ex_stall, load_use, redirect_ready,
        output flush, stall, redirect_valid, redirect_pc,
               mispredict_cnt, exception_cnt
    );

    modport master (
        output predict_miss, real_addr, exp_en, trap_entry, e_ret, epc,
               mem_stall, ex_stall, load_use, redirect_ready,
        input  flush, stall, redirect_valid, redirect_pc,
               mispredict_cnt, exception_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_redirect_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_redirect_scheduler
// Brief    : Redirect arbitration, per-stage flush/stall and fetch handshake.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_redirect_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    pipeline_redirect_scheduler_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_q, mispredict_cnt_d;
    logic [CNT_WIDTH-1:0]  exception_cnt_q, exception_cnt_d;

    logic       in_redirect;
    logic       trap_evt;
    logic       miss_evt;
    logic [4:0] flush_raw;
    logic [4:0] stall_raw;

    always_comb begin
        in_redirect = (state_q == ST_REDIRECT);
        trap_evt    = bus.exp_en | bus.e_ret;
        // A mispredict seen while a redirect is pending is from a killed path.
        miss_evt    = bus.predict_miss & ~trap_evt & ~in_redirect;

        flush_raw = 5'b00000;
        if (trap_evt) begin
            flush_raw = 5'b11110;
        end else if (miss_evt) begin
            flush_raw = 5'b11000;
        end else if (bus.load_use) begin
            flush_raw = 5'b00100;
        end
        if (in_redirect) begin
            flush_raw[4] = 1'b1;
        end

        stall_raw = 5'b00000;
        if (bus.mem_stall) begin
            stall_raw = 5'b11110;
        end else if (bus.ex_stall) begin
            stall_raw = 5'b11100;
        end else if (bus.load_use) begin
            stall_raw = 5'b11000;
        end
    end

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        exception_cnt_d  = exception_cnt_q;

        if (bus.exp_en) begin
            redirect_pc_d = bus.trap_entry;
        end else if (bus.e_ret) begin
            redirect_pc_d = bus.epc;
        end else if (miss_evt) begin
            redirect_pc_d = bus.real_addr;
        end

        // A new trap/ertn beats handshake completion in the same cycle.
        if (trap_evt) begin
            state_d         = ST_REDIRECT;
            exception_cnt_d = exception_cnt_q + CNT_WIDTH'(1);
        end else if (miss_evt) begin
            state_d          = ST_REDIRECT;
            mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
        end else if (in_redirect && bus.redirect_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
            exception_cnt_q  <= '0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            exception_cnt_q  <= exception_cnt_d;
        end
    end

    assign bus.flush          = rst_n ? flush_raw : 5'b00000;
    assign bus.stall          = rst_n ? (stall_raw & ~flush_raw) : 5'b00000;
    assign bus.redirect_valid = in_redirect;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
    assign bus.exception_cnt  = exception_cnt_q;

endmodule
`default_nettype wire
